// File: rtl/pwm_audio_pkg.sv
// Shared types and derived constants for the PWM audio output stage.
package pwm_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pwm_state_e;

  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_REPEAT   = 4;
  localparam int DEF_UCNT_W   = 8;

  // Width of the period-repeat counter; a single repeat still needs one bit.
  function automatic int rep_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int DEF_CNT_MAX = cnt_max(DEF_SAMPLE_W);
  localparam int DEF_REP_W   = rep_width(DEF_REPEAT);

endpackage

// File: rtl/pwm_audio_if.sv
// Sample handshake from the mixer: transfer when sample_valid && sample_ready at a rising clk edge.
interface pwm_audio_if #(
  parameter int SAMPLE_W = 8
);
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/sample_hold_buf.sv
// One-entry holding register between the mixer handshake and the PWM duty register.
module sample_hold_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic         consume,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  // A load in the same cycle as a consume replaces the consumed entry, so full stays set.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      if (load) begin
        full <= 1'b1;
        dout <= din;
      end else if (consume) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output: buffers mixer samples and plays each for REPEAT PWM periods, counting underruns.
module pwm_audio_out
  import pwm_audio_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int REPEAT   = DEF_REPEAT,
  parameter int UCNT_W   = DEF_UCNT_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  pwm_audio_if.slave        smp,
  output logic              pwm_out,
  output logic              frame_start,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_count,
  output pwm_state_e        dbg_state
);

  localparam int                  REP_W    = rep_width(REPEAT);
  localparam logic [SAMPLE_W-1:0] CNT_MAX  = SAMPLE_W'(cnt_max(SAMPLE_W));
  localparam logic [REP_W-1:0]    REP_LAST = REP_W'(REPEAT - 1);

  pwm_state_e          state, state_nxt;
  logic [SAMPLE_W-1:0] cnt, cnt_nxt;
  logic [REP_W-1:0]    rep, rep_nxt;
  logic [SAMPLE_W-1:0] duty, duty_nxt;
  logic [UCNT_W-1:0]   ucnt_nxt;
  logic                pwm_nxt, fs_nxt, ur_nxt;
  logic                ready, xfer, wrap;
  logic                hold_load, hold_consume, hold_clear, hold_full;
  logic [SAMPLE_W-1:0] hold_data;

  assign ready     = (state == PRIME) || ((state == RUN) && en && !hold_full);
  assign xfer      = smp.sample_valid && ready;
  assign wrap      = (cnt == CNT_MAX);
  assign hold_load = xfer && (state == RUN);

  assign smp.sample_ready = ready;
  assign dbg_state        = state;

  sample_hold_buf #(.W(SAMPLE_W)) u_hold (
    .clk     (clk),
    .nrst    (nrst),
    .load    (hold_load),
    .consume (hold_consume),
    .clear   (hold_clear),
    .din     (smp.sample_in),
    .dout    (hold_data),
    .full    (hold_full)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    rep_nxt      = '0;
    duty_nxt     = duty;
    ucnt_nxt     = underrun_count;
    ur_nxt       = 1'b0;
    hold_consume = 1'b0;
    hold_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = PRIME;
      end
      PRIME: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          state_nxt = RUN;
          duty_nxt  = smp.sample_in;
        end
      end
      RUN: begin
        cnt_nxt = cnt + 1'b1;
        rep_nxt = rep;
        if (wrap) rep_nxt = (rep == REP_LAST) ? '0 : rep + 1'b1;
        // Disable only takes effect at a period wrap so the last pulse is never truncated.
        if (wrap && !en) begin
          state_nxt  = IDLE;
          rep_nxt    = '0;
          duty_nxt   = '0;
          hold_clear = 1'b1;
        end else if (wrap && (rep == REP_LAST)) begin
          if (hold_full) begin
            duty_nxt     = hold_data;
            hold_consume = 1'b1;
          end else begin
            ur_nxt = 1'b1;
            if (underrun_count != '1) ucnt_nxt = underrun_count + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    pwm_nxt = (state_nxt == RUN) && (cnt_nxt < duty_nxt);
    fs_nxt  = (state_nxt == RUN) && (cnt_nxt == '0) && (rep_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state          <= IDLE;
      cnt            <= '0;
      rep            <= '0;
      duty           <= '0;
      pwm_out        <= 1'b0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      rep            <= rep_nxt;
      duty           <= duty_nxt;
      pwm_out        <= pwm_nxt;
      frame_start    <= fs_nxt;
      underrun       <= ur_nxt;
      underrun_count <= ucnt_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: frame-aligned directed stimulus feeding a per-frame expected queue.
module tb_pwm_audio_out;
  import pwm_audio_pkg::*;

  localparam int SAMPLE_W = 8;
  localparam int REPEAT   = 4;
  localparam int UCNT_W   = 3;
  localparam int PERIOD   = 1 << SAMPLE_W;
  localparam int FRAME    = REPEAT * PERIOD;

  // Entry: {first_frame, underrun, underrun_count, duty}
  localparam int EW = 1 + 1 + UCNT_W + SAMPLE_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic                en = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                sample_valid = 1'b0;
  logic                sample_ready;
  logic                pwm_out, frame_start, underrun;
  logic [UCNT_W-1:0]   underrun_count;
  pwm_state_e          dbg_state;

  pwm_audio_if #(.SAMPLE_W(SAMPLE_W)) sif ();
  assign sif.sample_in    = sample_in;
  assign sif.sample_valid = sample_valid;
  assign sample_ready     = sif.sample_ready;

  pwm_audio_out #(.SAMPLE_W(SAMPLE_W), .REPEAT(REPEAT), .UCNT_W(UCNT_W)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .smp            (sif.slave),
    .pwm_out        (pwm_out),
    .frame_start    (frame_start),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every frame_start pops one expected frame and checks one full PWM period.
  logic [EW-1:0] mon_e;
  int            mon_errs;
  int            last_fs = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (frame_start) begin
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("underrun_flag", {31'd0, underrun}, {31'd0, mon_e[EW-2]});
          chk("underrun_count", 32'(underrun_count), 32'(mon_e[SAMPLE_W +: UCNT_W]));
          if (!mon_e[EW-1]) chk("frame_interval", cyc - last_fs, FRAME);
          last_fs  = cyc;
          mon_errs = 0;
          for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) @(negedge clk);
            if (pwm_out !== (k < int'(mon_e[SAMPLE_W-1:0]))) mon_errs++;
          end
          chk("pwm_period", mon_errs, 0);
        end
      end else if (underrun) begin
        chk("stray_underrun", 32'd1, 32'd0);
      end
    end
  end

  // ---------------- bench model of the hold register ----------------
  logic                hold_v = 1'b0;
  logic [SAMPLE_W-1:0] hold_d = '0;
  logic [SAMPLE_W-1:0] cur    = '0;
  logic [UCNT_W-1:0]   ucnt   = '0;

  // ---------------- driver tasks ----------------
  // Called at a negedge while in PRIME; returns at the negedge of the first RUN cycle.
  task automatic prime_send(input logic [SAMPLE_W-1:0] s);
    chk("ready_prime", {31'd0, sample_ready}, 32'd1);
    sample_valid = 1'b1;
    sample_in    = s;
    cur          = s;
    exp_q.push_back({1'b1, 1'b0, ucnt, s});
    @(negedge clk);
    sample_valid = 1'b0;
    chk("state_run", 32'(dbg_state), 32'(RUN));
  endtask

  // Called at the negedge of cycle 0 of a frame; returns at cycle 0 of the next one.
  task automatic frame(input bit send, input logic [SAMPLE_W-1:0] s, input int off);
    chk("ready_frame_start", {31'd0, sample_ready}, {31'd0, !hold_v});
    for (int c = 0; c < FRAME; c++) begin
      if (send && c == off) begin
        sample_valid = 1'b1;
        sample_in    = s;
      end
      if (c == FRAME - 1) begin
        if (hold_v) cur = hold_d;
        else if (ucnt != '1) ucnt = ucnt + 1'b1;
        exp_q.push_back({1'b0, !hold_v, ucnt, cur});
        hold_v = 1'b0;
      end
      @(negedge clk);
      if (send && c == off) begin
        sample_valid = 1'b0;
        hold_v       = 1'b1;
        hold_d       = s;
        chk("ready_hold_full", {31'd0, sample_ready}, 32'd0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int highs;
  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_ucnt", 32'(underrun_count), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, sample_ready}, 32'd0);
    chk("idle_state", 32'(dbg_state), 32'(IDLE));
    en = 1'b1;
    @(negedge clk);

    // First sample, duty 0x40
    prime_send(8'h40);
    // Full-scale extremes, then starvation until the counter saturates
    frame(1'b1, 8'h00, 100);
    frame(1'b1, 8'hFF, 100);
    for (int i = 0; i < 9; i++) frame(1'b0, 8'h00, 0);
    // Sample offered exactly in the boundary cycle with hold empty
    frame(1'b1, 8'h80, FRAME - 1);
    frame(1'b0, 8'h00, 0);
    frame(1'b1, 8'hC0, 100);

    // Disable mid-period at cnt=100 while playing 0xC0
    repeat (100) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("ready_after_en_low", {31'd0, sample_ready}, 32'd0);
    repeat (PERIOD - 101) @(negedge clk);
    chk("pwm_after_stop", {31'd0, pwm_out}, 32'd0);
    chk("state_after_stop", 32'(dbg_state), 32'(IDLE));
    chk("ready_after_stop", {31'd0, sample_ready}, 32'd0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
    chk("pwm_idle_quiet", highs, 0);

    // Restart, fill hold, then reset mid-RUN
    en = 1'b1;
    @(negedge clk);
    hold_v = 1'b0;
    prime_send(8'h20);
    repeat (50) @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 8'h99;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("ready_full_before_rst", {31'd0, sample_ready}, 32'd0);
    repeat (249) @(negedge clk);
    nrst = 1'b0;
    en   = 1'b0;
    @(negedge clk);
    chk("rst2_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst2_fs", {31'd0, frame_start}, 32'd0);
    chk("rst2_underrun", {31'd0, underrun}, 32'd0);
    chk("rst2_ucnt", 32'(underrun_count), 32'd0);
    chk("rst2_ready", {31'd0, sample_ready}, 32'd0);
    chk("rst2_state", 32'(dbg_state), 32'(IDLE));
    nrst   = 1'b1;
    ucnt   = '0;
    hold_v = 1'b0;
    en     = 1'b1;
    @(negedge clk);
    // The discarded 0x99 must not appear: the next boundary is an underrun repeating 0x10
    prime_send(8'h10);
    frame(1'b0, 8'h00, 0);
    repeat (PERIOD + 4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
